// File: rtl/imem_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl_if
// Bus bundle between the IF-stage fetch controller, the instruction memory,
// the redirect source (branch/jump resolution) and the decode stage.
//
// Signals
//   imem_addr      byte address to IMEM (current PC)
//   imem_rdata     IMEM read data, combinational from imem_addr
//   redirect_valid branch/jump taken this cycle
//   redirect_pc    redirect target
//   out_valid      head fetch-buffer entry valid toward decode
//   out_ready      decode accepts the head entry
//   out_instr      head instruction (0 when !out_valid)
//   out_pc         PC of head instruction (0 when !out_valid)
//
// Modports
//   master : the fetch controller
//   slave  : the surrounding environment (IMEM, redirect source, decode)
// -----------------------------------------------------------------------------
interface imem_fetch_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_rdata;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_instr;
    logic [ADDR_WIDTH-1:0] out_pc;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
// IF-stage instruction memory sequencer. Owns the PC, drives the IMEM address
// combinationally (IMEM is zero-latency, so the fetched word is captured in the
// same cycle), buffers {pc, instr} pairs in a small FIFO and presents the head
// entry to decode over a valid/ready handshake. A taken branch/jump flushes the
// buffer and reloads the PC.
//
// Parameters
//   ADDR_WIDTH  PC / IMEM address width
//   RESET_PC    PC loaded on reset (word aligned)
//   FIFO_DEPTH  fetch buffer entries; power of 2, >= 2
//
// Ports
//   clk       in   clock, all state on rising edge
//   rst       in   synchronous active-high reset
//   fetch_en  in   1 = fetching allowed; 0 = hold PC, no pushes
//   bus       if   imem_fetch_ctrl_if.master (IMEM, redirect, decode handshake)
//   fault     out  misaligned-redirect fault
//
// Build option
//   FETCH_ALIGN_CHK_EN  when defined, a redirect to a non-word-aligned target
//                       flushes the buffer and parks the controller in FAULT
//                       (fault=1, sticky until rst). When undefined, the low
//                       two target bits are dropped and fault is tied 0.
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_en,
    imem_fetch_ctrl_if.master      bus,
    output logic                   fault
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  fault_q, fault_d;

    // Buffer storage: data only, never reset; validity is tracked by count_q.
    logic [ADDR_WIDTH-1:0] fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]           fifo_instr_q [FIFO_DEPTH];

    logic out_valid;
    logic push;
    logic pop;

    assign out_valid     = (count_q != '0);
    assign bus.imem_addr = pc_q;
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = out_valid ? fifo_pc_q[rd_ptr_q]    : '0;
    assign bus.out_instr = out_valid ? fifo_instr_q[rd_ptr_q] : '0;

    assign pop  = out_valid & bus.out_ready;
    // A full buffer still accepts a push when the head leaves in the same
    // cycle, so a steady stream runs without bubbles.
    assign push = (state_q == ST_RUN) & fetch_en & ~bus.redirect_valid &
                  ((count_q < CNT_W'(FIFO_DEPTH)) | pop);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fault_d  = fault_q;

        if (state_q == ST_FAULT) begin
            // Parked: buffer stays empty, pc frozen, redirects ignored.
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else if (bus.redirect_valid) begin
            // Flush wins over any pop this cycle; the popped entry is simply
            // discarded with the rest of the buffer.
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
`ifdef FETCH_ALIGN_CHK_EN
            if (bus.redirect_pc[1:0] != 2'b00) begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
            end else begin
                pc_d = bus.redirect_pc;
            end
`else
            pc_d = bus.redirect_pc & ~ADDR_WIDTH'(3);
`endif
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                pc_d     = pc_q + ADDR_WIDTH'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fault_q  <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= pc_q;
            fifo_instr_q[wr_ptr_q] <= bus.imem_rdata;
        end
    end

`ifdef FETCH_ALIGN_CHK_EN
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

endmodule
